// File: rtl/hex_entry_input_pkg.sv
// hex_entry_input_pkg
//   Shared definitions for the hex entry front end: FSM state encoding,
//   target register select codes and the default legal register count.
package hex_entry_input_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_SEND  = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [2:0] REG_RA = 3'd0;
    localparam logic [2:0] REG_RB = 3'd1;
    localparam logic [2:0] REG_RZ = 3'd2;
    localparam logic [2:0] REG_RM = 3'd3;
    localparam logic [2:0] REG_RY = 3'd4;

    localparam int unsigned NUM_REGS_DEFAULT = 5;

endpackage

// File: rtl/hex_entry_input_key_debouncer.sv
// key_debouncer
//   Synchronizes one active-low pushbutton, debounces it and emits a
//   single-cycle pulse when the debounced key becomes pressed.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   key_n  in   raw pushbutton, active-low, asynchronous
//   press  out  1-cycle pulse on debounced released->pressed transition
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    // Internally the key is tracked active-high (1 = pressed).
    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Level accepted; only the pressed direction yields an event.
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hex_entry_input.sv
// hex_entry_input
//   Operator hex-entry front end: assembles a 32-bit word one nibble at a
//   time from switches, then issues one valid/ready register write.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   sw_nibble       hex digit switches (asynchronous)
//   sw_reg_sel      target register switches (asynchronous)
//   key_enter_n     shift nibble into word (active-low)
//   key_commit_n    send word to register (active-low)
//   key_clear_n     discard entry / clear error (active-low)
//   wr_valid/ready  write handshake toward register file
//   wr_reg_sel      target register of current write
//   wr_data         write data
//   entry_word      word under construction (preview)
//   nibble_count    nibbles entered, 0..8
//   err             illegal register select at commit
module hex_entry_input
    import hex_entry_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned NUM_REGS        = NUM_REGS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_nibble,
    input  logic [2:0]  sw_reg_sel,
    input  logic        key_enter_n,
    input  logic        key_commit_n,
    input  logic        key_clear_n,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [2:0]  wr_reg_sel,
    output logic [31:0] wr_data,
    output logic [31:0] entry_word,
    output logic [3:0]  nibble_count,
    output logic        err
);

    logic enter_ev;
    logic commit_ev;
    logic clear_ev;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
        .clk(clk), .reset(reset), .key_n(key_enter_n), .press(enter_ev)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_commit (
        .clk(clk), .reset(reset), .key_n(key_commit_n), .press(commit_ev)
    );
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
        .clk(clk), .reset(reset), .key_n(key_clear_n), .press(clear_ev)
    );

    // Switch synchronizers
    logic [3:0] nib_s1, nib_sync;
    logic [2:0] sel_s1, sel_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nib_s1   <= '0;
            nib_sync <= '0;
            sel_s1   <= '0;
            sel_sync <= '0;
        end else begin
            nib_s1   <= sw_nibble;
            nib_sync <= nib_s1;
            sel_s1   <= sw_reg_sel;
            sel_sync <= sel_s1;
        end
    end

    state_t      state, state_next;
    logic [31:0] word_next;
    logic [3:0]  count_next;
    logic [31:0] data_next;
    logic [2:0]  sel_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_ENTRY;
            entry_word   <= '0;
            nibble_count <= '0;
            wr_data      <= '0;
            wr_reg_sel   <= '0;
        end else begin
            state        <= state_next;
            entry_word   <= word_next;
            nibble_count <= count_next;
            wr_data      <= data_next;
            wr_reg_sel   <= sel_next;
        end
    end

    always_comb begin
        state_next = state;
        word_next  = entry_word;
        count_next = nibble_count;
        data_next  = wr_data;
        sel_next   = wr_reg_sel;
        unique case (state)
            ST_ENTRY: begin
                // Priority clear > commit > enter; losers are dropped.
                if (clear_ev) begin
                    word_next  = '0;
                    count_next = '0;
                end else if (commit_ev) begin
                    if (nibble_count != 4'd0) begin
                        if (32'(sel_sync) >= NUM_REGS) begin
                            state_next = ST_ERR;
                        end else begin
                            data_next  = entry_word;
                            sel_next   = sel_sync;
                            state_next = ST_SEND;
                        end
                    end
                end else if (enter_ev && nibble_count < 4'd8) begin
                    word_next  = {entry_word[27:0], nib_sync};
                    count_next = nibble_count + 4'd1;
                end
            end
            ST_SEND: begin
                // Keys are ignored here; the write always completes.
                if (wr_ready) begin
                    state_next = ST_ENTRY;
                    word_next  = '0;
                    count_next = '0;
                end
            end
            ST_ERR: begin
                if (clear_ev) begin
                    state_next = ST_ENTRY;
                    word_next  = '0;
                    count_next = '0;
                end
            end
            default: state_next = ST_ENTRY;
        endcase
    end

    // Decoded straight from the state flops so reset drops them at once.
    assign wr_valid = (state == ST_SEND);
    assign err      = (state == ST_ERR);

endmodule

// File: doc/hex_entry_input.md
Name: hex_entry_input

Overview:
- Operator-input counterpart to the seven-segment register display. Converts switch and pushbutton activity into 32-bit register writes for the processor.
- User keys a word one hex nibble at a time, picks a target register (0=RA, 1=RB, 2=RZ, 3=RM, 4=RY), then commits.
- On commit, the block issues a single valid/ready write toward the register file.
- The partially entered word is exported so the display path can preview it.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles a synchronized key level must hold steady before it is accepted (5 ms at 50 MHz)
CNT_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES
NUM_REGS, 5, count of legal target registers; selects >= NUM_REGS are errors

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sw_nibble  in  4  hex digit from switches (asynchronous)
sw_reg_sel  in  3  target register select from switches (asynchronous)
key_enter_n  in  1  pushbutton, active-low: shift sw_nibble into word
key_commit_n  in  1  pushbutton, active-low: send word to register
key_clear_n  in  1  pushbutton, active-low: discard entry / clear error
wr_valid  out  1  write request valid
wr_ready  in  1  register file accepts write
wr_reg_sel  out  3  target register of current write
wr_data  out  32  write data
entry_word  out  32  word being assembled (display preview)
nibble_count  out  4  nibbles entered, 0..8
err  out  1  illegal register select at commit

Behaviour:
- Reset (async, any state): all outputs 0, FSM=ENTRY, debounced key state = released, counters 0.
- Synchronization: each key and both switch buses pass through a 2-flop synchronizer. Switches are sampled only from their synchronized copies.
- Debounce, per key:
  - Counter clears whenever the synchronized level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press event is a 1-cycle pulse on the debounced released->pressed transition. Release produces no event.
- Event latency: DEBOUNCE_CYCLES+3 cycles after a clean key edge.
- Simultaneous events in one cycle are prioritized clear > commit > enter; lower-priority events are dropped.
- FSM ENTRY:
  - enter, count<8: entry_word <= {entry_word[27:0], sw_nibble}; count+1.
  - enter, count==8: ignored; word and count unchanged.
  - clear: entry_word=0, count=0.
  - commit, count==0: ignored.
  - commit, sw_reg_sel>=NUM_REGS: go to ERR, err=1; word is retained.
  - commit, otherwise: wr_data<=entry_word, wr_reg_sel<=sw_reg_sel, wr_valid=1 from the next cycle; go to SEND.
- FSM SEND:
  - wr_valid, wr_data and wr_reg_sel are held stable until wr_ready is sampled high.
  - Accept cycle (wr_valid & wr_ready): next cycle wr_valid=0, entry_word=0, count=0, go to ENTRY. Exactly one write per commit.
  - All key events, including clear, are ignored in SEND; a started write is never aborted.
  - wr_ready high outside SEND has no effect.
- FSM ERR:
  - err=1; enter and commit are ignored.
  - clear: err=0, entry_word=0, count=0, go to ENTRY.
- Reset mid-SEND: wr_valid drops immediately; the pending write is lost by design.
- wr_data is don't-care while wr_valid=0 but is held at its last value; no X is ever driven.

Decomposition:
- Shared package: FSM state encoding (ENTRY, SEND, ERR), register-select constants REG_RA..REG_RY, and NUM_REGS default.
- Sub-module key_debouncer (synchronizer + counter + press pulse), instantiated three times with DEBOUNCE_CYCLES passed through.
- Switch synchronizers stay in the top level.

Test Plan (bench uses DEBOUNCE_CYCLES=4, wr_ready tied 1 unless stated):
- Enter nibbles 1,2,3,4,5,6,7,8 in sequence, select 2, commit -> entry_word=0x12345678, count=8 before commit; one cycle of wr_valid with wr_reg_sel=2, wr_data=0x12345678; afterwards entry_word=0, count=0.
- 9th enter with sw_nibble=F after 8 nibbles -> word stays 0x12345678, count stays 8.
- Key bounce: key_enter_n toggles every 2 cycles for 10 cycles, then holds low -> exactly one nibble shift, occurring DEBOUNCE_CYCLES+3 cycles after the final stable edge.
- wr_ready held 0 for 20 cycles after commit of 0xA5, with enter/clear pressed meanwhile -> wr_valid high and wr_data=0x000000A5 stable throughout; count unaffected; on wr_ready=1, exactly one accept.
- Commit with sw_reg_sel=6 -> err=1, no wr_valid; enter/commit ignored; clear -> err=0, word=0.
- Clear and commit events in the same cycle with word 0x3 -> no write, word cleared. Separately, assert reset during SEND -> wr_valid low without waiting for a clock edge; all outputs 0.
